// File: rtl/systolic_feeder.sv
// Weight-tile buffer and diagonal feature skew feeding an N x N weight-stationary systolic array.
// Optional weight reuse across passes is enabled by defining SYSTOLIC_FEEDER_WREUSE_EN.
module systolic_feeder #(
    parameter int WIDTH = 8,
    parameter int N     = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [15:0]        num_vec,
    input  logic               reuse_w,
    input  logic               w_valid,
    output logic               w_ready,
    input  logic [N*WIDTH-1:0] w_data,
    input  logic               f_valid,
    output logic               f_ready,
    input  logic [N*WIDTH-1:0] f_data,
    output logic               pe_ctrl,
    output logic [N*WIDTH-1:0] pe_top,
    output logic [N*WIDTH-1:0] feat_out,
    output logic [N-1:0]       feat_en,
    output logic               busy,
    output logic               done
);

    localparam int          IDX        = $clog2(N);
    localparam logic [15:0] LAST_ROW   = 16'(N - 1);
    localparam logic [15:0] DRAIN_LAST = 16'(2 * N - 2);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_W_FILL  = 3'd1,
        S_W_SHIFT = 3'd2,
        S_STREAM  = 3'd3,
        S_DRAIN   = 3'd4
    } state_t;

    state_t             state_r, state_s;
    logic [15:0]        cnt_r, cnt_s;
    logic [15:0]        nv_r, nv_s;
    logic               w_we_s;
    logic               xfer_s;
    logic               drain_end_s;
    logic               reuse_s;
    logic               pe_ctrl_r;
    logic [N*WIDTH-1:0] pe_top_r;
    logic               busy_r;
    logic               done_r;
    logic [N*WIDTH-1:0] wbuf_r [N];

`ifdef SYSTOLIC_FEEDER_WREUSE_EN
    assign reuse_s = reuse_w;
`else
    logic unused_reuse_s;
    assign unused_reuse_s = reuse_w;
    assign reuse_s        = 1'b0;
`endif

    assign w_ready  = (state_r == S_W_FILL);
    assign f_ready  = (state_r == S_STREAM);
    assign pe_ctrl  = pe_ctrl_r;
    assign pe_top   = pe_top_r;
    assign busy     = busy_r;
    assign done     = done_r;

    // Next-state and counter logic; the cycle carrying done does not accept start.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        nv_s        = nv_r;
        w_we_s      = 1'b0;
        xfer_s      = 1'b0;
        drain_end_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start && !done_r) begin
                    nv_s    = num_vec;
                    cnt_s   = 16'd0;
                    state_s = reuse_s ? S_W_SHIFT : S_W_FILL;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_W_FILL: begin
                if (w_valid) begin
                    w_we_s = 1'b1;
                    if (cnt_r == LAST_ROW) begin
                        cnt_s   = 16'd0;
                        state_s = S_W_SHIFT;
                    end else begin
                        cnt_s = cnt_r + 16'd1;
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            S_W_SHIFT: begin
                if (cnt_r == LAST_ROW) begin
                    cnt_s   = 16'd0;
                    state_s = (nv_r == 16'd0) ? S_DRAIN : S_STREAM;
                end else begin
                    cnt_s = cnt_r + 16'd1;
                end
            end
            S_STREAM: begin
                if (f_valid) begin
                    xfer_s = 1'b1;
                    if (cnt_r == nv_r - 16'd1) begin
                        cnt_s   = 16'd0;
                        state_s = S_DRAIN;
                    end else begin
                        cnt_s = cnt_r + 16'd1;
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            S_DRAIN: begin
                if (cnt_r == DRAIN_LAST) begin
                    drain_end_s = 1'b1;
                    cnt_s       = 16'd0;
                    state_s     = S_IDLE;
                end else begin
                    cnt_s = cnt_r + 16'd1;
                end
            end
            default: begin
                state_s = S_IDLE;
                cnt_s   = 16'd0;
            end
        endcase
    end

    // State, weight buffer and array-top outputs; pe_top is looked up with the next
    // counter value so the burst lines up with the W_SHIFT state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= S_IDLE;
            cnt_r     <= 16'd0;
            nv_r      <= 16'd0;
            pe_ctrl_r <= 1'b0;
            pe_top_r  <= {(N*WIDTH){1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            for (int i = 0; i < N; i++) begin
                wbuf_r[i] <= {(N*WIDTH){1'b0}};
            end
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            nv_r      <= nv_s;
            pe_ctrl_r <= (state_s == S_W_SHIFT);
            pe_top_r  <= (state_s == S_W_SHIFT) ? wbuf_r[cnt_s[IDX-1:0]] : {(N*WIDTH){1'b0}};
            busy_r    <= (state_s != S_IDLE) || drain_end_s;
            done_r    <= drain_end_s;
            if (w_we_s) begin
                wbuf_r[cnt_r[IDX-1:0]] <= w_data;
            end
        end
    end

    for (genvar r = 0; r < N; r++) begin : g_row
        logic [WIDTH-1:0] d_r [0:r];
        logic [r:0]       e_r;

        // Row r delay line: r+1 registers, bubbles enter whenever no vector transfers.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int j = 0; j <= r; j++) begin
                    d_r[j] <= {WIDTH{1'b0}};
                end
                e_r <= '0;
            end else begin
                d_r[0] <= xfer_s ? f_data[r*WIDTH +: WIDTH] : {WIDTH{1'b0}};
                e_r[0] <= xfer_s;
                for (int j = 1; j <= r; j++) begin
                    d_r[j] <= d_r[j-1];
                    e_r[j] <= e_r[j-1];
                end
            end
        end

        assign feat_out[r*WIDTH +: WIDTH] = d_r[r];
        assign feat_en[r]                 = e_r[r];
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed self-checking bench for systolic_feeder (N=4, WIDTH=8); checks the reuse
// path when SYSTOLIC_FEEDER_WREUSE_EN is defined, the full-fill path otherwise.
module tb_systolic_feeder;
    localparam int WIDTH = 8;
    localparam int N     = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [15:0]        num_vec;
    logic               reuse_w;
    logic               w_valid;
    logic               w_ready;
    logic [N*WIDTH-1:0] w_data;
    logic               f_valid;
    logic               f_ready;
    logic [N*WIDTH-1:0] f_data;
    logic               pe_ctrl;
    logic [N*WIDTH-1:0] pe_top;
    logic [N*WIDTH-1:0] feat_out;
    logic [N-1:0]       feat_en;
    logic               busy;
    logic               done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    localparam logic [31:0] V0 = 32'h04030201;
    localparam logic [31:0] V1 = 32'h08070605;

    always #5 clk = ~clk;

    systolic_feeder #(.WIDTH(WIDTH), .N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .num_vec(num_vec), .reuse_w(reuse_w),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .f_valid(f_valid), .f_ready(f_ready), .f_data(f_data),
        .pe_ctrl(pe_ctrl), .pe_top(pe_top), .feat_out(feat_out), .feat_en(feat_en),
        .busy(busy), .done(done)
    );

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] wrow(input logic [7:0] b);
        return {b + 8'd3, b + 8'd2, b + 8'd1, b};
    endfunction

    task automatic begin_pass(input logic [15:0] nv, input logic ru);
        num_vec = nv;
        reuse_w = ru;
        start   = 1'b1;
        cyc     = 0;
        tick();
        start   = 1'b0;
        num_vec = 16'd0;
        reuse_w = 1'b0;
        chk("busy_rise", busy, 1);
    endtask

    task automatic fill_shift(input logic [7:0] b, input int stall);
        for (int k = 0; k < 4; k++) begin
            if (k == 2) begin
                for (int s = 0; s < stall; s++) begin
                    w_valid = 1'b0;
                    w_data  = 32'hDEADBEEF;
                    tick();
                    chk("stall_no_ctrl", pe_ctrl, 0);
                    chk("stall_w_ready", w_ready, 1);
                end
            end
            chk("fill_w_ready", w_ready, 1);
            chk("fill_no_ctrl", pe_ctrl, 0);
            w_valid = 1'b1;
            w_data  = wrow(b + 8'(k * 16));
            tick();
        end
        w_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("shift_ctrl", pe_ctrl, 1);
            chk("shift_top", pe_top, wrow(b + 8'(k * 16)));
            chk("shift_feat_quiet", {feat_out, feat_en}, 0);
            if (k < 3) tick();
        end
        tick();
        chk("shift_end_ctrl", pe_ctrl, 0);
        chk("shift_end_top", pe_top, 0);
    endtask

    task automatic stream_skew(input int bubble);
        int t0;
        int t1;
        int tc;
        t0 = cyc;
        t1 = t0 + 1 + bubble;
        chk("stream_f_ready", f_ready, 1);
        while (cyc < t1 + 5) begin
            f_valid = (cyc == t0) || (cyc >= t1);
            f_data  = (cyc == t0) ? V0 : ((cyc == t1) ? V1 : 32'hDEADBEEF);
            tick();
            if (cyc == t1 + 1) chk("drain_f_ready", f_ready, 0);
            for (int r = 0; r < 4; r++) begin
                tc = cyc - 1 - r;
                chk("skew_data", feat_out[r*8 +: 8], (tc == t0) ? r + 1 : ((tc == t1) ? r + 5 : 0));
                chk("skew_en", feat_en[r], (tc == t0) || (tc == t1));
            end
        end
        f_valid = 1'b0;
    endtask

    task automatic wait_done(input int exp_cyc);
        f_valid = 1'b0;
        w_valid = 1'b0;
        while (done !== 1'b1 && cyc < 80) tick();
        chk("done_cycle", cyc, exp_cyc);
        chk("done_busy", busy, 1);
        tick();
        chk("done_one_cycle", done, 0);
        chk("busy_fall", busy, 0);
    endtask

    initial begin
        int seen;
        rst = 1'b1; start = 1'b0; num_vec = 16'd0; reuse_w = 1'b0;
        w_valid = 1'b0; w_data = 32'd0; f_valid = 1'b0; f_data = 32'd0;
        tick();
        tick();
        chk("rst_ctrl_top", {pe_ctrl, pe_top}, 0);
        chk("rst_feat", {feat_out, feat_en}, 0);
        chk("rst_busy_done", {busy, done}, 0);
        chk("rst_ready", {w_ready, f_ready}, 0);
        rst = 1'b0;
        tick();

        // Basic load, no vectors: done at 1+4+4+0+7 = 16
        begin_pass(16'd0, 1'b0);
        fill_shift(8'h10, 0);
        wait_done(16);

        // Weight stall of 3 cycles, started back-to-back after done
        begin_pass(16'd0, 1'b0);
        fill_shift(8'h20, 3);
        wait_done(19);

        // Skew with two vectors
        begin_pass(16'd2, 1'b0);
        fill_shift(8'h30, 0);
        stream_skew(0);
        wait_done(18);

        // One-cycle bubble between vectors
        begin_pass(16'd2, 1'b0);
        fill_shift(8'h40, 0);
        stream_skew(1);
        wait_done(19);

`ifdef SYSTOLIC_FEEDER_WREUSE_EN
        w_valid = 1'b1;
        w_data  = 32'hDEADBEEF;
        begin_pass(16'd0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            chk("reuse_no_w_ready", w_ready, 0);
            chk("reuse_ctrl", pe_ctrl, 1);
            chk("reuse_top", pe_top, wrow(8'h40 + 8'(k * 16)));
            tick();
        end
        chk("reuse_end_ctrl", pe_ctrl, 0);
        wait_done(12);
`else
        begin_pass(16'd0, 1'b1);
        fill_shift(8'h50, 0);
        wait_done(16);
`endif

        // Reset in the middle of STREAM
        begin_pass(16'd5, 1'b0);
        fill_shift(8'h60, 0);
        f_valid = 1'b1;
        f_data  = V0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst     = 1'b0;
        f_valid = 1'b0;
        chk("midrst_ctrl_top", {pe_ctrl, pe_top}, 0);
        chk("midrst_feat", {feat_out, feat_en}, 0);
        chk("midrst_busy_done", {busy, done}, 0);
        chk("midrst_ready", {w_ready, f_ready}, 0);
        seen = 0;
        repeat (25) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        chk("midrst_no_done", seen, 0);

        // Fresh pass after reset, single vector
        begin_pass(16'd1, 1'b0);
        fill_shift(8'h70, 0);
        f_valid = 1'b1;
        f_data  = V1;
        tick();
        f_valid = 1'b0;
        chk("post_rst_row0_data", feat_out[7:0], 8'h05);
        chk("post_rst_row0_en", feat_en, 4'b0001);
        wait_done(17);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
